// File: rtl/pal_cfg_loader.sv
// PAL configuration loader: takes the bitstream from a host as W-bit words over
// valid/ready and serialises exactly SR_LEN bits, MSB first, onto the PAL EN/CFG chain.
module pal_cfg_loader #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int P = 8,
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic         START,
  input  logic         ABORT,
  input  logic [W-1:0] DIN,
  input  logic         DIN_VALID,
  output logic         DIN_READY,
  output logic         SR_EN,
  output logic         SR_CFG,
  output logic         BUSY,
  output logic         CFG_VALID
);

  localparam int SR_LEN    = 2 * N * P + P * M;
  localparam int NWORDS    = (SR_LEN + W - 1) / W;
  localparam int LAST_BITS = SR_LEN - (NWORDS - 1) * W;
  localparam int CW        = $clog2(W + 1);
  localparam int WCW       = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t         r_state;

  logic [W-1:0]   r_hb_p0;
  logic           r_hb_full_p0;
  logic [WCW-1:0] r_words_p0;

  logic [W-1:0]   r_shr_p1;
  logic [CW-1:0]  r_sh_cnt_p1;
  logic           r_last_p1;

  logic           w_ready;
  logic           w_accept;
  logic           w_shift;
  logic           w_reload;
  logic           w_hb_last;
  logic           w_done;

  assign w_ready   = (r_state == S_LOAD) && !r_hb_full_p0 && (r_words_p0 < WCW'(NWORDS));
  assign w_accept  = w_ready && DIN_VALID;
  assign w_shift   = (r_sh_cnt_p1 != '0);
  assign w_reload  = r_hb_full_p0 &&
                     ((r_sh_cnt_p1 == '0) || ((r_sh_cnt_p1 == CW'(1)) && w_shift));
  // A full buffer always holds the most recently accepted word.
  assign w_hb_last = (r_words_p0 == WCW'(NWORDS));
  assign w_done    = (r_state == S_LOAD) && r_last_p1 && (r_sh_cnt_p1 == CW'(1));

  // Stage p0: host word capture into the holding buffer
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_hb_p0 <= DIN;
    end
  end

  // Stage p1: control FSM, buffer bookkeeping and the output shift register
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state      <= S_IDLE;
      r_hb_full_p0 <= 1'b0;
      r_words_p0   <= '0;
      r_shr_p1     <= '0;
      r_sh_cnt_p1  <= '0;
      r_last_p1    <= 1'b0;
    end else if (ABORT) begin
      r_state      <= S_IDLE;
      r_hb_full_p0 <= 1'b0;
      r_words_p0   <= '0;
      r_sh_cnt_p1  <= '0;
      r_last_p1    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state      <= S_LOAD;
            r_hb_full_p0 <= 1'b0;
            r_words_p0   <= '0;
            r_sh_cnt_p1  <= '0;
            r_last_p1    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_hb_full_p0 <= 1'b1;
            r_words_p0   <= r_words_p0 + WCW'(1);
          end
          // Reloading on the last shift cycle keeps SR_EN gap-free.
          if (w_reload) begin
            r_shr_p1     <= r_hb_p0;
            r_sh_cnt_p1  <= w_hb_last ? CW'(LAST_BITS) : CW'(W);
            r_last_p1    <= w_hb_last;
            r_hb_full_p0 <= 1'b0;
          end else if (w_shift) begin
            r_shr_p1    <= r_shr_p1 << 1;
            r_sh_cnt_p1 <= r_sh_cnt_p1 - CW'(1);
          end
          if (w_done) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DIN_READY = w_ready;
  assign SR_EN     = w_shift;
  assign SR_CFG    = r_shr_p1[W-1];
  assign BUSY      = (r_state == S_LOAD);
  assign CFG_VALID = (r_state == S_DONE);

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Bench for pal_cfg_loader: a cycle table on a small (15-bit) instance and
// randomized host traffic on the default (192-bit) instance against a bitstream model.
module tb_pal_cfg_loader;

  localparam int SR_LEN = 192;
  localparam int NW     = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic res;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_START, a_ABORT, a_DIN_VALID, a_DIN_READY, a_SR_EN, a_SR_CFG, a_BUSY, a_CFG_VALID;
  logic [7:0] a_DIN;
  logic       b_START, b_ABORT, b_DIN_VALID, b_DIN_READY, b_SR_EN, b_SR_CFG, b_BUSY, b_CFG_VALID;
  logic [7:0] b_DIN;

  pal_cfg_loader #(.N(8), .M(8), .P(8), .W(8)) dut_a (
    .CLK(clk), .RES(res), .START(a_START), .ABORT(a_ABORT), .DIN(a_DIN),
    .DIN_VALID(a_DIN_VALID), .DIN_READY(a_DIN_READY), .SR_EN(a_SR_EN),
    .SR_CFG(a_SR_CFG), .BUSY(a_BUSY), .CFG_VALID(a_CFG_VALID)
  );

  pal_cfg_loader #(.N(2), .M(1), .P(3), .W(8)) dut_b (
    .CLK(clk), .RES(res), .START(b_START), .ABORT(b_ABORT), .DIN(b_DIN),
    .DIN_VALID(b_DIN_VALID), .DIN_READY(b_DIN_READY), .SR_EN(b_SR_EN),
    .SR_CFG(b_SR_CFG), .BUSY(b_BUSY), .CFG_VALID(b_CFG_VALID)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor of the big instance's config chain
  bit mon_on = 1'b0;
  bit cap_q[$];
  int en_cnt, first_en, last_en, t0;
  always @(negedge clk) begin
    if (mon_on && a_SR_EN) begin
      cap_q.push_back(a_SR_CFG);
      if (en_cnt == 0) first_en = cyc - t0;
      last_en = cyc - t0;
      en_cnt++;
    end
  end

  logic [7:0] src[NW];

  task automatic run_load(input int bubble_after, input int bubble_len, input bit rnd_gaps,
                          input int abort_at, input int start_at, input bit first_a5,
                          input bit timing_chk, input string tag);
    bit exp_q[$];
    int idx, gap_left, ready_first, valid_at, busy_at_valid, en_at_valid, nmis;
    bit aborted, dv, rdy;
    logic [7:0] first_byte;
    for (int i = 0; i < NW; i++) src[i] = 8'($urandom_range(0, 255));
    if (first_a5) src[0] = 8'hA5;
    for (int w = 0; w < NW; w++)
      for (int b = 7; b >= 0; b--)
        if (exp_q.size() < SR_LEN) exp_q.push_back(src[w][b]);

    @(negedge clk);
    cap_q.delete();
    en_cnt = 0; first_en = -1; last_en = -1; t0 = cyc; mon_on = 1'b1;
    chk({tag, "_ready_c0"}, a_DIN_READY, 0);
    a_START = 1'b1; a_ABORT = 1'b0; a_DIN_VALID = 1'b0;
    idx = 0; gap_left = 0; ready_first = -1; valid_at = -1; aborted = 1'b0;
    busy_at_valid = -1; en_at_valid = -1;
    @(posedge clk);
    for (int k = 1; k < 3000; k++) begin
      @(negedge clk);
      a_START = (start_at >= 0 && idx == start_at);
      a_ABORT = 1'b0;
      if (a_CFG_VALID) begin
        valid_at = k; busy_at_valid = a_BUSY; en_at_valid = a_SR_EN;
        break;
      end
      if (ready_first < 0 && a_DIN_READY) ready_first = k;
      if (abort_at >= 0 && idx == abort_at) begin
        a_ABORT = 1'b1; a_DIN_VALID = 1'b1; a_START = 1'b0;
        @(negedge clk);
        a_ABORT = 1'b0; a_DIN_VALID = 1'b0;
        chk({tag, "_abort_sr_en"}, a_SR_EN, 0);
        chk({tag, "_abort_cfg_valid"}, a_CFG_VALID, 0);
        chk({tag, "_abort_din_ready"}, a_DIN_READY, 0);
        chk({tag, "_abort_busy"}, a_BUSY, 0);
        aborted = 1'b1;
        break;
      end
      if (gap_left > 0) begin
        dv = 1'b0; gap_left--;
      end else if (rnd_gaps) dv = ($urandom_range(0, 3) != 0);
      else dv = 1'b1;
      a_DIN_VALID = dv;
      a_DIN = (idx < NW) ? src[idx] : 8'hFF;
      rdy = a_DIN_READY;
      @(posedge clk);
      if (rdy && dv) begin
        idx++;
        if (idx == bubble_after && bubble_len > 0) gap_left = bubble_len;
      end
    end
    a_START = 1'b0; a_ABORT = 1'b0; a_DIN_VALID = 1'b0;
    mon_on = 1'b0;
    if (aborted) return;

    chk({tag, "_completed"}, (valid_at >= 0), 1);
    chk({tag, "_en_pulses"}, en_cnt, SR_LEN);
    chk({tag, "_words_taken"}, idx, NW);
    chk({tag, "_busy_in_done"}, busy_at_valid, 0);
    chk({tag, "_en_in_done"}, en_at_valid, 0);
    nmis = 0;
    for (int i = 0; i < SR_LEN; i++)
      if (i >= cap_q.size() || cap_q[i] != exp_q[i]) nmis++;
    chk({tag, "_bit_errors"}, nmis, 0);
    if (timing_chk) begin
      first_byte = '0;
      for (int i = 0; i < 8 && i < cap_q.size(); i++) first_byte[7-i] = cap_q[i];
      chk({tag, "_ready_first_cycle"}, ready_first, 1);
      chk({tag, "_first_en_cycle"}, first_en, 3);
      chk({tag, "_last_en_cycle"}, last_en, 194);
      chk({tag, "_cfg_valid_cycle"}, valid_at, 195);
      chk({tag, "_first_byte"}, first_byte, 8'hA5);
    end
    if (bubble_len > 0) chk({tag, "_has_gap"}, (last_en - first_en + 1 > en_cnt), 1);
  endtask

  typedef struct {
    bit st, ab, dv;
    logic [7:0] din;
    bit rdy, en, cfg, busy, val;
  } vec_t;

  function automatic vec_t mk(bit st, bit ab, bit dv, logic [7:0] din,
                              bit rdy, bit en, bit cfg, bit busy, bit val);
    vec_t v;
    v.st = st; v.ab = ab; v.dv = dv; v.din = din;
    v.rdy = rdy; v.en = en; v.cfg = cfg; v.busy = busy; v.val = val;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Partial-last-word load on the 15-bit chain, then DONE/ABORT corner cases
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hFF, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hFF, 1, 1, 0, 1, 0));
    for (int i = 4; i <= 10; i++) tbl.push_back(mk(0, 0, 1, 8'hFF, 0, 1, 0, 1, 0));
    for (int i = 11; i <= 17; i++) tbl.push_back(mk(0, 0, 1, 8'hFF, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0));

    // Reset held two cycles with START and DIN_VALID asserted
    res = 1'b1;
    a_START = 1'b1; a_ABORT = 1'b0; a_DIN_VALID = 1'b1; a_DIN = 8'h5A;
    b_START = 1'b1; b_ABORT = 1'b0; b_DIN_VALID = 1'b1; b_DIN = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    a_START = 1'b0; a_DIN_VALID = 1'b0;
    b_START = 1'b0; b_DIN_VALID = 1'b0;
    chk("rst_a_ready", a_DIN_READY, 0);
    chk("rst_a_en", a_SR_EN, 0);
    chk("rst_a_cfg", a_SR_CFG, 0);
    chk("rst_a_busy", a_BUSY, 0);
    chk("rst_a_valid", a_CFG_VALID, 0);
    chk("rst_b_outputs", {b_DIN_READY, b_SR_EN, b_SR_CFG, b_BUSY, b_CFG_VALID}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_en", a_SR_EN, 0);
      chk("idle_not_busy", a_BUSY, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      b_START = tbl[i].st; b_ABORT = tbl[i].ab; b_DIN_VALID = tbl[i].dv; b_DIN = tbl[i].din;
      chk($sformatf("tbl%0d_ready", i), b_DIN_READY, tbl[i].rdy);
      chk($sformatf("tbl%0d_en", i), b_SR_EN, tbl[i].en);
      if (tbl[i].en) chk($sformatf("tbl%0d_cfg", i), b_SR_CFG, tbl[i].cfg);
      chk($sformatf("tbl%0d_busy", i), b_BUSY, tbl[i].busy);
      chk($sformatf("tbl%0d_valid", i), b_CFG_VALID, tbl[i].val);
    end
    @(negedge clk);
    b_START = 1'b0; b_ABORT = 1'b0; b_DIN_VALID = 1'b0;

    run_load(-1, 0, 1'b0, -1, -1, 1'b1, 1'b1, "cont");
    run_load(5, 20, 1'b0, -1, -1, 1'b0, 1'b0, "bubble");
    run_load(-1, 0, 1'b0, 11, -1, 1'b0, 1'b0, "abort");
    run_load(-1, 0, 1'b0, -1, -1, 1'b1, 1'b1, "after_abort");
    run_load(-1, 0, 1'b0, -1, 12, 1'b0, 1'b0, "start_mid");

    // START while DONE restarts the load on the next cycle
    @(negedge clk);
    chk("done_valid", a_CFG_VALID, 1);
    a_START = 1'b1;
    @(negedge clk);
    a_START = 1'b0;
    chk("restart_busy", a_BUSY, 1);
    chk("restart_valid", a_CFG_VALID, 0);
    a_ABORT = 1'b1;
    @(negedge clk);
    a_ABORT = 1'b0;
    chk("restart_abort_idle", a_BUSY, 0);

    for (int r = 0; r < 3; r++) run_load(-1, 0, 1'b1, -1, -1, 1'b0, 1'b0, $sformatf("rnd%0d", r));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
